// File: rtl/raster_scan_gen.sv
// raster_scan_gen: walks the full screen or a window, issuing ROM addresses with x/y/plot one cycle behind
//   clk, reset             clock, asynchronous active-high reset
//   start, abort           begin a scan (IDLE only) / cancel the scan in progress
//   windowMode             0 = full screen, 1 = window given by xStart/yStart/width/height
//   ready                  adapter accepts a pixel this cycle; everything holds while low
//   addr                   linear ROM read address relative to the scan origin
//   x, y, plot             pixel position and write-enable, aligned with ROM data
//   busy, done             high in SCAN/FLUSH; one-cycle pulse on completion
module raster_scan_gen #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              windowMode,
  input  logic [X_W-1:0]    xStart,
  input  logic [Y_W-1:0]    yStart,
  input  logic [X_W-1:0]    width,
  input  logic [Y_W-1:0]    height,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              plot,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic [X_W-1:0]    x0_q, x0_d, w_q, w_d, col_q, col_d, x_q, x_d;
  logic [Y_W-1:0]    y0_q, y0_d, h_q, h_d, row_q, row_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pv_q, pv_d, clip_q, clip_d;
  logic [X_W:0]      xs;
  logic [Y_W:0]      ys;
  logic              clip_now, col_last, last;
  // one extra bit so a window hanging off the right/bottom edge clips instead of wrapping
  assign xs       = {1'b0, x0_q} + {1'b0, col_q};
  assign ys       = {1'b0, y0_q} + {1'b0, row_q};
  assign clip_now = (xs >= (X_W+1)'(SCREEN_W)) || (ys >= (Y_W+1)'(SCREEN_H));
  assign col_last = col_q == w_q - X_W'(1);
  assign last     = col_last && (row_q == h_q - Y_W'(1));
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    pv_d    = pv_q;
    clip_d  = clip_q;
    if (state_q == IDLE) begin
      if (start) begin
        x0_d    = windowMode ? xStart : '0;
        y0_d    = windowMode ? yStart : '0;
        w_d     = windowMode ? width  : X_W'(SCREEN_W);
        h_d     = windowMode ? height : Y_W'(SCREEN_H);
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        pv_d    = 1'b0;
        state_d = (w_d == '0 || h_d == '0) ? DONE : SCAN;
      end
    end else if (abort) begin
      state_d = IDLE;
      pv_d    = 1'b0;
    end else if (state_q == SCAN) begin
      if (ready) begin
        x_d     = xs[X_W-1:0];
        y_d     = ys[Y_W-1:0];
        clip_d  = clip_now;
        pv_d    = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        col_d   = col_last ? '0 : col_q + X_W'(1);
        row_d   = col_last ? row_q + Y_W'(1) : row_q;
        state_d = last ? FLUSH : SCAN;
      end
    end else if (state_q == FLUSH) begin
      if (ready) begin
        pv_d    = 1'b0;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pv_q    <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pv_q    <= pv_d;
      clip_q  <= clip_d;
    end
  end
  assign addr = addr_q;
  assign x    = x_q;
  assign y    = y_q;
  assign plot = pv_q & ready & ~clip_q;
  assign busy = (state_q == SCAN) || (state_q == FLUSH);
  assign done = state_q == DONE;
endmodule

// File: tb/tb_raster_scan_gen.sv
// tb_raster_scan_gen: scoreboard bench for raster_scan_gen
module tb_raster_scan_gen;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, windowMode = 1'b0, ready = 1'b1;
  logic [7:0]  xStart = '0, width = '0, x;
  logic [6:0]  yStart = '0, height = '0, y;
  logic [14:0] addr;
  logic        plot, busy, done;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [14:0] a;} pix_t;
  pix_t        exp_q[$];
  pix_t        e;
  int          vectors = 0, errors = 0;
  int          plots = 0, dones = 0, busy_cycles = 0, cyc = 0, last_plot_cyc = 0, done_cyc = 0;
  logic [7:0]  last_px = '0;
  logic [6:0]  last_py = '0;
  logic [14:0] last_issued = '0;

  raster_scan_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .windowMode(windowMode),
    .xStart(xStart), .yStart(yStart), .width(width), .height(height), .ready(ready),
    .addr(addr), .x(x), .y(y), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // monitor: every presented pixel is matched against the head of the expected queue
  always @(negedge clk) begin
    cyc++;
    if (plot) begin
      plots++;
      last_px = x;
      last_py = y;
      last_plot_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got x=%0d y=%0d addr=%0d, queue empty", x, y, last_issued);
      end else begin
        e = exp_q.pop_front();
        if (x !== e.x || y !== e.y || last_issued !== e.a) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d addr=%0d want x=%0d y=%0d addr=%0d",
                   x, y, last_issued, e.x, e.y, e.a);
        end
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (busy) busy_cycles++;
    if (busy && ready) last_issued = addr;
  end

  task automatic chk(input string n, input longint act, input longint want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, want);
    end
  endtask

  task automatic push_model(input int x0, input int y0, input int w, input int h);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x0 + c < 160 && y0 + r < 120) begin
          p.x = 8'(x0 + c);
          p.y = 7'(y0 + r);
          p.a = 15'(r * w + c);
          exp_q.push_back(p);
        end
  endtask

  task automatic go(input bit wm, input int x0, input int y0, input int w, input int h);
    plots = 0;
    dones = 0;
    busy_cycles = 0;
    if (wm) push_model(x0, y0, w, h);
    else push_model(0, 0, 160, 120);
    windowMode = wm;
    xStart = 8'(x0);
    yStart = 7'(y0);
    width  = 8'(w);
    height = 7'(h);
    ready  = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    xStart = 8'd77;
    yStart = 7'd33;
    width  = 8'd1;
    height = 7'd1;
  endtask

  task automatic run(input string n, input bit wm, input int x0, input int y0, input int w,
                     input int h, input bit tog, input int want_plots);
    int t;
    go(wm, x0, y0, w, h);
    t = 0;
    while (dones == 0 && t < 30000) begin
      @(posedge clk); #1;
      if (tog) ready = ~ready;
      t++;
    end
    chk({n, "_no_timeout"}, longint'(t < 30000), 1);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({n, "_plots"}, plots, want_plots);
    chk({n, "_dones"}, dones, 1);
    chk({n, "_leftover"}, exp_q.size(), 0);
    chk({n, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_async_addr", addr, 0);
    chk("rst_async_plot", plot, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    run("full", 1'b0, 0, 0, 0, 0, 1'b0, 19200);
    chk("full_busy_cycles", busy_cycles, 19201);
    chk("full_last_x", last_px, 159);
    chk("full_last_y", last_py, 119);
    chk("full_done_after_last", done_cyc - last_plot_cyc, 1);

    run("win", 1'b1, 10, 20, 4, 3, 1'b0, 12);
    chk("win_last_x", last_px, 13);
    chk("win_last_y", last_py, 22);
    run("clip", 1'b1, 158, 118, 4, 4, 1'b0, 4);
    chk("clip_last_x", last_px, 159);
    chk("clip_last_y", last_py, 119);
    run("toggle", 1'b1, 10, 20, 4, 3, 1'b1, 12);

    go(1'b1, 10, 20, 4, 3);
    for (int i = 0; i < 100 && plots < 5; i++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached5", plots, 5);
    abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_plot_low", plot, 0);
    chk("abort_busy_low", busy, 0);
    #1 abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", dones, 0);
    chk("abort_plots", plots, 5);
    run("after_abort", 1'b1, 10, 20, 4, 3, 1'b0, 12);

    go(1'b1, 5, 5, 0, 3);
    @(negedge clk);
    chk("w0_done_next", done, 1);
    chk("w0_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("w0_plots", plots, 0);
    chk("w0_dones", dones, 1);

    go(1'b0, 0, 0, 0, 0);
    repeat (50) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_addr", addr, 0);
    chk("midrst_xy", {x, y}, 0);
    chk("midrst_plot", plot, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", busy, 0);
    run("after_rst", 1'b1, 0, 0, 2, 2, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
